// File: rtl/xnor_match_pkg.sv
// Shared types and helpers for the XNOR match accumulator.
//   state_e  : frame FSM states (DRAIN only with XNOR_MATCH_ACC_PIPE_EN)
//   sumw_f   : width of a frame sum that cannot overflow
//   pcw_f    : width of a single-word popcount
// Build option: XNOR_MATCH_ACC_PIPE_EN adds the drain state used by the
// registered-popcount variant.
package xnor_match_pkg;

`ifdef XNOR_MATCH_ACC_PIPE_EN
   typedef enum logic [1:0] {
      StAccum = 2'd0,
      StHold  = 2'd1,
      StDrain = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      StAccum = 2'd0,
      StHold  = 2'd1
   } state_e;
`endif

   function automatic int unsigned sumw_f(input int unsigned width,
                                          input int unsigned frame_len);
      return $clog2(width * frame_len + 1);
   endfunction

   function automatic int unsigned pcw_f(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational popcount built as a balanced binary adder tree.
//   WIDTH   : number of input bits
//   bits_i  : input vector
//   count_o : number of set bits in bits_i
// Leaves are padded with zeros up to the next power of two.
module popcount_tree
   import xnor_match_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]          bits_i,
   output logic [pcw_f(WIDTH)-1:0]   count_o
);

   localparam int unsigned PCW    = pcw_f(WIDTH);
   localparam int unsigned LEVELS = $clog2(WIDTH);
   localparam int unsigned LEAVES = 1 << LEVELS;

   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int unsigned CNT = LEAVES >> l;
      logic [PCW-1:0] s [CNT];
      for (genvar i = 0; i < CNT; i++) begin : g_node
         if (l == 0) begin : g_leaf
            if (i < WIDTH) begin : g_bit
               assign s[i] = PCW'(bits_i[i]);
            end else begin : g_pad
               assign s[i] = '0;
            end
         end else begin : g_add
            assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
         end
      end
   end

   assign count_o = g_lvl[LEVELS].s[0];

endmodule

// File: rtl/xnor_match_acc.sv
// Frame-level match accumulator fed by an XNOR stage.
// Sums the popcount of FRAME_LEN accepted words, then holds the frame total
// and a threshold flag until the consumer takes it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous frame abort, highest priority
//   in_valid/in_ready   : word handshake, in_bits = XNOR vector (1 = match)
//   out_valid/out_ready : result handshake
//   out_sum, out_match  : frame total and (out_sum >= THRESH)
// Build option: XNOR_MATCH_ACC_PIPE_EN registers the popcount (with valid and
// last flags) ahead of the adder; a drain state closes each frame.
module xnor_match_acc
   import xnor_match_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FRAME_LEN = 16,
   parameter int unsigned THRESH    = 96
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH-1:0]                    in_bits,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [sumw_f(WIDTH, FRAME_LEN)-1:0] out_sum,
   output logic                                out_match
);

   localparam int unsigned SUMW = sumw_f(WIDTH, FRAME_LEN);
   localparam int unsigned PCW  = pcw_f(WIDTH);
   localparam int unsigned WCW  = $clog2(FRAME_LEN);

   state_e          state_q, state_d;
   logic [SUMW-1:0] sum_q, sum_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [SUMW-1:0] out_sum_q, out_sum_d;
   logic            out_match_q, out_match_d;

   logic [PCW-1:0]  pc;
   logic            accept;
   logic            is_last;
   logic            add_en;
   logic            add_last;
   logic [PCW-1:0]  add_val;
   logic [SUMW-1:0] sum_new;

   popcount_tree #(
      .WIDTH (WIDTH)
   ) u_popcount (
      .bits_i  (in_bits),
      .count_o (pc)
   );

   // clear discards a word offered in the same cycle
   assign accept  = in_valid & in_ready & ~clear;
   assign is_last = (wcnt_q == WCW'(FRAME_LEN - 1));

`ifdef XNOR_MATCH_ACC_PIPE_EN
   logic           pv_q, pv_d;
   logic           plast_q, plast_d;
   logic [PCW-1:0] pc_q, pc_d;

   // accept already excludes clear, so a clear flushes the stage
   always_comb begin
      pv_d    = accept;
      plast_d = accept & is_last;
      pc_d    = pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_q    <= 1'b0;
         plast_q <= 1'b0;
         pc_q    <= '0;
      end else begin
         pv_q    <= pv_d;
         plast_q <= plast_d;
         pc_q    <= pc_d;
      end
   end

   assign add_en   = pv_q;
   assign add_last = plast_q;
   assign add_val  = pc_q;
`else
   assign add_en   = accept;
   assign add_last = is_last;
   assign add_val  = pc;
`endif

   assign sum_new = sum_q + SUMW'(add_val);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StAccum;
         sum_q       <= '0;
         wcnt_q      <= '0;
         out_sum_q   <= '0;
         out_match_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         wcnt_q      <= wcnt_d;
         out_sum_q   <= out_sum_d;
         out_match_q <= out_match_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      wcnt_d      = wcnt_q;
      out_sum_d   = out_sum_q;
      out_match_d = out_match_q;

      if (clear) begin
         state_d = StAccum;
         sum_d   = '0;
         wcnt_d  = '0;
      end else begin
         if (accept) begin
            wcnt_d = is_last ? '0 : wcnt_q + 1'b1;
         end

         if (add_en) begin
            if (add_last) begin
               sum_d       = '0;
               out_sum_d   = sum_new;
               out_match_d = (32'(sum_new) >= THRESH);
            end else begin
               sum_d = sum_new;
            end
         end

         unique case (state_q)
            StAccum: begin
               if (accept && is_last) begin
`ifdef XNOR_MATCH_ACC_PIPE_EN
                  state_d = StDrain;
`else
                  state_d = StHold;
`endif
               end
            end
`ifdef XNOR_MATCH_ACC_PIPE_EN
            // last popcount is in the stage register; it lands next edge
            StDrain: state_d = StHold;
`endif
            StHold: begin
               if (out_ready) begin
                  state_d = StAccum;
               end
            end
            default: state_d = StAccum;
         endcase
      end
   end

   // Outputs; in_ready is gated by rst_n so it reads 0 throughout reset
   always_comb begin
      in_ready  = rst_n & (state_q == StAccum);
      out_valid = (state_q == StHold);
      out_sum   = out_sum_q;
      out_match = out_match_q;
   end

endmodule

// File: tb/tb_xnor_match_acc.sv
module tb_xnor_match_acc;
   import xnor_match_pkg::*;

   localparam int unsigned W    = 8;
   localparam int unsigned FL   = 4;
   localparam int unsigned TH   = 24;
   localparam int unsigned SUMW = sumw_f(W, FL);
`ifdef XNOR_MATCH_ACC_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            clear = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_bits = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [SUMW-1:0] out_sum;
   logic            out_match;

   xnor_match_acc #(
      .WIDTH     (W),
      .FRAME_LEN (FL),
      .THRESH    (TH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bits   (in_bits),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_match (out_match)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: frame bookkeeping in plain integers
   int m_sum    = 0;
   int m_cnt    = 0;
   bit pending  = 0;
   int exp_sum  = 0;
   int acc_cyc  = 0;
   int cyc      = 0;
   int n_frames = 0;
   int n_xfer   = 0;
   int last_sum = -1;
   int last_match = -1;
   int hold_run = 0;
   int last_hold = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive, check at mid-cycle, update model, advance
   task automatic cycle(input bit v, input logic [W-1:0] b, input bit ordy, input bit clr);
      bit exp_ov;
      bit acc;
      bit xfer;
      in_valid  = v;
      in_bits   = b;
      out_ready = ordy;
      clear     = clr;
      #4;
      exp_ov = pending && ((cyc - acc_cyc) >= LAT);
      check_eq("in_ready", int'(in_ready), int'(!pending));
      check_eq("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov) begin
         check_eq("out_sum", int'(out_sum), exp_sum);
         check_eq("out_match", int'(out_match), int'(exp_sum >= int'(TH)));
      end
      if (out_valid) hold_run++;
      acc  = v && !pending && !clr;
      xfer = exp_ov && ordy && !clr;
      if (clr) begin
         m_sum   = 0;
         m_cnt   = 0;
         pending = 0;
      end else begin
         if (xfer) begin
            pending    = 0;
            n_xfer++;
            last_sum   = int'(out_sum);
            last_match = int'(out_match);
            last_hold  = hold_run;
         end
         if (acc) begin
            m_sum += $countones(b);
            m_cnt++;
            if (m_cnt == int'(FL)) begin
               exp_sum = m_sum;
               pending = 1;
               acc_cyc = cyc;
               m_sum   = 0;
               m_cnt   = 0;
               n_frames++;
            end
         end
      end
      if (!out_valid) hold_run = 0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, ordy, 1'b0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      clear    = 1'b0;
      rst_n    = 1'b0;
      #3;
      check_eq("rst_in_ready", int'(in_ready), 0);
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_out_sum", int'(out_sum), 0);
      check_eq("rst_out_match", int'(out_match), 0);
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      m_sum   = 0;
      m_cnt   = 0;
      pending = 0;
      hold_run = 0;
      cyc++;
   endtask

   initial begin
      int xs;
      logic [W-1:0] w [4];

      // Reset state
      #2;
      check_eq("init_in_ready", int'(in_ready), 0);
      check_eq("init_out_valid", int'(out_valid), 0);
      check_eq("init_out_sum", int'(out_sum), 0);
      check_eq("init_out_match", int'(out_match), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full-match frame, consumer always ready
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("ff_sum", last_sum, 32);
      check_eq("ff_match", last_match, 1);
      check_eq("ff_hold_len", last_hold, 1);

      // Sparse frame below threshold
      w = '{8'h0F, 8'h03, 8'h00, 8'h01};
      for (int i = 0; i < 4; i++) cycle(1'b1, w[i], 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("low_sum", last_sum, 7);
      check_eq("low_match", last_match, 0);

      // Exactly at threshold
      w = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
      for (int i = 0; i < 4; i++) cycle(1'b1, w[i], 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("thr_sum", last_sum, 24);
      check_eq("thr_match", last_match, 1);

      // Consumer stalls 5 cycles; offered words must be ignored
      xs = n_xfer;
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      idle(4, 1'b1);
      check_eq("stall_xfers", n_xfer - xs, 1);
      check_eq("stall_sum", last_sum, 32);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h01, 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("after_stall_sum", last_sum, 4);

      // clear mid-frame
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      cycle(1'b1, 8'hFF, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h01, 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("clear_sum", last_sum, 4);

      // clear during HOLD discards the result
      xs = n_xfer;
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      idle(2, 1'b0);
      check_eq("pre_clear_valid", int'(out_valid), 1);
      cycle(1'b0, '0, 1'b1, 1'b1);
      idle(4, 1'b1);
      check_eq("clear_hold_xfers", n_xfer - xs, 0);

      // Randomized stalls over 100 frames
      xs = n_frames;
      for (int i = 0; i < 20000 && (n_frames - xs) < 100; i++) begin
         cycle(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 99) == 0));
      end
      check_eq("rand_frames_done", int'((n_frames - xs) >= 100), 1);
      idle(4, 1'b1);

      // Reset while holding a result, then reset mid-frame
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h7F, 1'b0, 1'b0);
      idle(3, 1'b0);
      do_reset();
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      cycle(1'b1, 8'hFF, 1'b1, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h03, 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("post_reset_sum", last_sum, 8);
      check_eq("post_reset_match", last_match, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xnor_match_acc.md
# xnor_match_acc

Frame-level match accumulator that sits directly downstream of the `nxorgate` XNOR stage. It accepts one WIDTH-bit XNOR result per handshake, where each 1 bit marks an agreeing bit position, and adds the word's popcount into a running sum. After FRAME_LEN words it presents the frame total and a threshold-match flag. It is used for pattern or sync-word correlation and for bit-error counting against a reference sequence.

## Interface
- `WIDTH`, 8: width of the XNOR vector per word.
- `FRAME_LEN`, 16: words per frame; must be ≥ 2.
- `THRESH`, 96: minimum frame sum that asserts `out_match`.
- `SUMW`, derived (not overridable): `$clog2(WIDTH*FRAME_LEN+1)`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous frame abort; highest priority.
- `in_valid`, in, 1: `in_bits` is valid.
- `in_ready`, out, 1: block can accept a word.
- `in_bits`, in, WIDTH: XNOR vector (1 = bit match).
- `out_valid`, out, 1: frame result is valid.
- `out_ready`, in, 1: consumer takes the result.
- `out_sum`, out, SUMW: total matching bits in the frame.
- `out_match`, out, 1: `out_sum >= THRESH`.

## Operation
- Two states:
  - ACCUM: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- A word is accepted when `in_valid & in_ready`:
  - `sum <= sum + popcount(in_bits)`.
  - `wcnt <= wcnt + 1`.
  - `wcnt` counts 0..FRAME_LEN-1.
- Last word (accepted while `wcnt == FRAME_LEN-1`):
  - `out_sum` is loaded with `sum + popcount`.
  - `out_match` is computed from that same value.
  - `sum` and `wcnt` return to 0.
  - State moves to HOLD.
- HOLD:
  - `out_sum` and `out_match` stay stable until `out_valid & out_ready`, then the state returns to ACCUM.
  - Upstream is backpressured; `in_bits` is ignored.
- Arithmetic: unsigned; `SUMW` guarantees no overflow, so there is no wrap and no saturation.
- `clear`:
  - Zeroes `sum` and `wcnt`, drops `out_valid`, and forces ACCUM.
  - A word presented in the same cycle is discarded.
  - A result held in HOLD is discarded.
- `in_valid` held low: the state is retained indefinitely; there is no timeout.
- Reset values:
  - `in_ready=0` while `rst_n` is low; 1 in the first cycle after deassertion.
  - `out_valid=0`, `out_sum=0`, `out_match=0`.
  - State ACCUM, `sum=0`, `wcnt=0`.
- Reset in mid-frame loses the partial sum with no output.

## Timing
- Handshake rules:
  - Standard valid/ready.
  - `in_ready` does not depend combinationally on `in_valid`.
  - `out_valid` does not depend on `out_ready`.
  - `out_valid` never drops without a transfer, except on `clear` or reset.
- Base latency: last word accepted at edge t, `out_valid=1` after edge t (visible in cycle t+1).
- Throughput:
  - One word per cycle in ACCUM.
  - One bubble cycle per frame, since HOLD lasts at least one cycle.
  - Best case is FRAME_LEN+1 cycles per frame.
- `out_ready` may be held high permanently; HOLD then lasts exactly one cycle.

## Configuration
- Macro: `XNOR_MATCH_ACC_PIPE_EN`.
- Without the macro:
  - Popcount is combinational into the adder.
  - Latency is 1 cycle, as in Timing.
- With the macro:
  - The popcount result is registered, together with a valid flag and a last flag, before the adder.
  - `out_valid` rises 2 cycles after the last word is accepted.
  - `in_ready` drops in the cycle after the last word is accepted; this is a drain substate inside ACCUM.
  - `clear` also flushes the pipe register.
- Frame sums are identical in both builds.

## Structure
- Package `xnor_match_pkg`:
  - State enum (ACCUM, HOLD, plus DRAIN under the macro).
  - Function `sumw_f(width, frame_len)`.
  - Function for the popcount width `$clog2(WIDTH+1)`.
- Sub-module `popcount_tree`:
  - Parameterized by `WIDTH`, purely combinational adder tree.
  - Instantiated once.
  - Also reused by other correlator blocks.

## Test plan
All cases use WIDTH=8, FRAME_LEN=4, THRESH=24.
- Four words of 8'hFF, `out_ready=1` → `out_sum=32`, `out_match=1`, one cycle after the 4th accept; HOLD lasts 1 cycle.
- Words 8'h0F, 8'h03, 8'h00, 8'h01 → `out_sum=7`, `out_match=0`.
- Frame sum exactly 24 (8'hFF, 8'hFF, 8'hFF, 8'h00) → `out_match=1`.
- Frame completes with `out_ready` low for 5 cycles → `in_ready=0` and `out_sum` stable all 5 cycles; exactly one transfer; the next frame starts from sum 0.
- `clear` after 2 words of 8'hFF, then 4 words of 8'h01 → `out_sum=4`. A second run pulses `clear` during HOLD → `out_valid` drops and the result is never transferred.
- Random `in_valid`/`out_ready` stalls over 100 frames, built with and without `XNOR_MATCH_ACC_PIPE_EN` → sums match the reference model; latency is 1 and 2 cycles respectively; reset asserted mid-frame → all outputs return to reset values.
